// File: rtl/crc_pkg.sv
// ----------------------------------------------------------------------------
// crc_pkg : shared packet-type codes, payload widths and scheduler FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package crc_pkg;

    localparam int TOKEN_W  = 27;
    localparam int DATA_W   = 80;
    localparam int HSHAKE_W = 16;

    // Encodings are fixed by the crc block's pkt_in decoder
    typedef enum logic [1:0] {
        PKT_IDLE   = 2'b00,
        PKT_TOKEN  = 2'b01,
        PKT_HSHAKE = 2'b10,
        PKT_DATA   = 2'b11
    } pkt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ANNOUNCE = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_ENDR     = 3'd3,
        ST_DRAIN    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/piso_shift.sv
// ----------------------------------------------------------------------------
// piso_shift : parallel-in serial-out payload shifter, LSB first, narrower
//              payloads zero-extended on load
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module piso_shift
    import crc_pkg::*;
#(
    parameter int W     = 80,
    parameter int HS_W  = 16,
    parameter int TOK_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  pkt_type_e        sel_i,
    input  logic [HS_W-1:0]  hs_pkt_i,
    input  logic [TOK_W-1:0] tok_pkt_i,
    input  logic [W-1:0]     data_pkt_i,
    output logic             bit_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            case (sel_i)
                PKT_HSHAKE: sr_d = W'(hs_pkt_i);
                PKT_TOKEN:  sr_d = W'(tok_pkt_i);
                default:    sr_d = data_pkt_i;
            endcase
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = sr_q[0];

endmodule

`default_nettype wire

// File: rtl/crc_tx_sched.sv
// ----------------------------------------------------------------------------
// crc_tx_sched : hs > tok > data packet scheduler feeding the crc block
//                Optional DRAIN timeout enabled by macro CRC_TX_TIMEOUT_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module crc_tx_sched #(
    parameter int TOKEN_W   = crc_pkg::TOKEN_W,
    parameter int DATA_W    = crc_pkg::DATA_W,
    parameter int HSHAKE_W  = crc_pkg::HSHAKE_W,
    parameter int DRAIN_MAX = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hs_req_i,
    input  logic [HSHAKE_W-1:0] hs_pkt_i,
    input  logic                tok_req_i,
    input  logic [TOKEN_W-1:0]  tok_pkt_i,
    input  logic                data_req_i,
    input  logic [DATA_W-1:0]   data_pkt_i,
    output logic                hs_gnt_o,
    output logic                tok_gnt_o,
    output logic                data_gnt_o,
    output logic [1:0]          pkt_in_o,
    output logic                s_in_o,
    output logic                endr_o,
    input  logic                endb_i,
    output logic                busy_o,
    output logic                err_o
);

    import crc_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    state_e          state_q, state_d;
    pkt_type_e       type_q,  type_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic w_load;
    logic w_shift;
    logic w_bit;
    logic w_tmo_hit;

    piso_shift #(
        .W     (DATA_W),
        .HS_W  (HSHAKE_W),
        .TOK_W (TOKEN_W)
    ) u_piso (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .shift_i    (w_shift),
        .sel_i      (type_d),
        .hs_pkt_i   (hs_pkt_i),
        .tok_pkt_i  (tok_pkt_i),
        .data_pkt_i (data_pkt_i),
        .bit_o      (w_bit)
    );

`ifdef CRC_TX_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;

    // Held at zero outside DRAIN so it reads 0 on the first DRAIN cycle
    assign tmo_d     = (state_q == ST_DRAIN) ? tmo_q + 8'd1 : 8'd0;
    assign w_tmo_hit = (state_q == ST_DRAIN) && (tmo_q == 8'(DRAIN_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        cnt_d      = cnt_q;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        hs_gnt_o   = 1'b0;
        tok_gnt_o  = 1'b0;
        data_gnt_o = 1'b0;
        pkt_in_o   = PKT_IDLE;
        s_in_o     = 1'b0;
        endr_o     = 1'b0;
        busy_o     = 1'b1;
        err_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                // No grant during a reset cycle, so a request is never consumed silently
                if (rst_n) begin
                    if (hs_req_i) begin
                        hs_gnt_o = 1'b1;
                        type_d   = PKT_HSHAKE;
                        cnt_d    = CNT_W'(HSHAKE_W - 1);
                        w_load   = 1'b1;
                        state_d  = ST_ANNOUNCE;
                    end else if (tok_req_i) begin
                        tok_gnt_o = 1'b1;
                        type_d    = PKT_TOKEN;
                        cnt_d     = CNT_W'(TOKEN_W - 1);
                        w_load    = 1'b1;
                        state_d   = ST_ANNOUNCE;
                    end else if (data_req_i) begin
                        data_gnt_o = 1'b1;
                        type_d     = PKT_DATA;
                        cnt_d      = CNT_W'(DATA_W - 1);
                        w_load     = 1'b1;
                        state_d    = ST_ANNOUNCE;
                    end
                end
            end
            ST_ANNOUNCE: begin
                pkt_in_o = type_q;
                err_o    = endb_i;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                s_in_o  = w_bit;
                w_shift = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                err_o   = endb_i;
                if (cnt_q == '0) begin
                    state_d = ST_ENDR;
                end
            end
            ST_ENDR: begin
                endr_o  = 1'b1;
                err_o   = endb_i;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // endb beats a simultaneous timeout
                if (endb_i) begin
                    state_d = ST_IDLE;
                end else if (w_tmo_hit) begin
                    err_o   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            type_q  <= PKT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/crc_tx_sched.md
Name: crc_tx_sched

Overview:
- Packet-level scheduler in front of the `crc` block.
- Arbitrates between three transmit requesters: handshake, token and data.
- For the granted packet it announces the type on `pkt_in`, streams the payload serially on `s_in`, pulses `endr`, then holds off further packets until the `crc`/bit-stuffer path reports completion on `endb`.

Parameters:
- TOKEN_W, 27, token payload bits streamed (must match token size).
- DATA_W, 80, data payload bits streamed (must match data size).
- HSHAKE_W, 16, handshake payload bits streamed.
- DRAIN_MAX, 255, cycles allowed in DRAIN before timeout (used only with the optional feature); 8-bit counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- hs_req  input  1  handshake request; held until hs_gnt.
- hs_pkt  input  HSHAKE_W  handshake payload, LSB sent first.
- tok_req  input  1  token request; held until tok_gnt.
- tok_pkt  input  TOKEN_W  token payload, LSB first.
- data_req  input  1  data request; held until data_gnt.
- data_pkt  input  DATA_W  data payload, LSB first.
- hs_gnt, tok_gnt, data_gnt  output  1 each  one-cycle grant; payload latched this cycle.
- pkt_in  output  2  packet type code to crc (00 idle, 01 token, 11 data, 10 handshake).
- s_in  output  1  serial payload bit to crc.
- endr  output  1  end-of-payload strobe to crc.
- endb  input  1  packet fully drained from crc/bit-stuffer.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle protocol/timeout error pulse.

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE; all outputs 0; shift register, bit counter and timeout counter cleared. Reset mid-packet aborts the packet with no endr issued.
- States: IDLE, ANNOUNCE, SHIFT, ENDR, DRAIN.
- IDLE:
  - If any req, grant by fixed priority hs > tok > data.
  - Pulse the matching *_gnt and latch its *_pkt into the shift register.
  - Load counter = width-1, store type code, go to ANNOUNCE.
  - With no req, stay in IDLE.
- ANNOUNCE (1 cycle): pkt_in = stored code, s_in = 0, go to SHIFT.
- SHIFT (exactly N cycles, N = width of granted type):
  - s_in = shift_reg[0], then shift right and decrement the counter.
  - pkt_in = 00.
  - When counter==0 this cycle, go to ENDR.
- ENDR (1 cycle): endr = 1, s_in = 0, go to DRAIN.
- DRAIN: wait for endb=1, then go to IDLE. The next grant is possible in the cycle after endb is seen.
- Latency figures:
  - gnt to first payload bit: 2 cycles.
  - gnt to endr: N+2 cycles.
  - Minimum packet-to-packet gap is N+3 cycles plus the DRAIN time.
- pkt_in is non-zero only in ANNOUNCE. It is never re-asserted while busy, which prevents a crc restart.
- Requests arriving while busy are not granted. They stay pending, and priority is re-evaluated in IDLE.
- Simultaneous requests: only the winner gets a grant; the others keep waiting.
- endb seen in ANNOUNCE, SHIFT or ENDR: err pulses 1 cycle, endb is otherwise ignored, and the packet continues.
- endb seen in IDLE: ignored, no err.
- No backpressure on s_in: the crc fifo absorbs bit-stuffer pause.

Optional Feature:
- Macro: CRC_TX_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - If it reaches DRAIN_MAX without endb: err pulses 1 cycle and the state returns to IDLE.
  - endb arriving in that same cycle wins: normal exit, no err.
- When undefined: DRAIN waits indefinitely; err reports only early endb.

Decomposition:
- Shared package crc_pkg:
  - Type-code typedef (enum logic [1:0] PKT_IDLE/TOKEN/HSHAKE/DATA).
  - Width constants TOKEN_W/DATA_W/HSHAKE_W.
  - FSM state enum.
- Sub-module `piso_shift`: parallel-in serial-out shifter of width DATA_W with load, shift and zero-extension of narrower payloads. The width-1 count lives in the FSM.

Test Plan:
- tok_req=1, tok_pkt=27'h5A5A5A5: tok_gnt at cycle t, pkt_in=01 at t+1, s_in sequence LSB-first at t+2..t+28, endr at t+29; endb at t+40 → busy=0 at t+41.
- hs_req, tok_req and data_req all raised in the same cycle, endb returned 5 cycles after each endr → grants in order hs, tok, data; exactly one *_gnt per packet; pkt_in 10, 01, 11.
- data_req with data_pkt=80'h1 → s_in=1 only on the first SHIFT cycle; 80 SHIFT cycles total; endr high for 1 cycle.
- endb=1 pulsed during SHIFT of a handshake → err=1 for 1 cycle, endr still issued after 16 bits.
- rst_n=0 at the 10th SHIFT cycle of a data packet → next cycle all outputs 0 and state IDLE; a held data_req is re-granted afterwards with the full 80 bits.
- CRC_TX_TIMEOUT_EN, DRAIN_MAX=20, endb never asserted → err pulse 20 cycles after DRAIN entry, busy falls, pending tok_req then granted.
